shadow_dcache_arbiter: RTL and testbench

- Shares the single dcache request port between the LSU store path and the shadow register save controller (ShRU).
- Locks the port to one requester from request until `data_gnt`, so a transaction's payload is never mixed between requesters.
- Gives ShRU saves priority, with a bounded-starvation guarantee for the LSU.
- Sits between the EX-stage store unit / shadow save controller and the dcache port.

---
 rtl/shadow_dcache_arbiter_pkg.sv | 49 ++++
 rtl/shadow_dcache_arbiter.sv | 148 ++++++++++++++
 tb/tb_shadow_dcache_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shadow_dcache_arbiter_pkg.sv
// Shared types for the shadow-save / LSU dcache port arbiter: cache request and
// response structs, core configuration record and the arbitration state encodings.
package shadow_dcache_arbiter_pkg;

    localparam int unsigned STALL_W = 8;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned DCacheIdWidth;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 0, DCacheIdWidth: 0};

    typedef struct packed {
        logic [11:0] address_index;
        logic [19:0] address_tag;
        logic [63:0] data_wdata;
        logic        data_wuser;
        logic        data_req;
        logic        data_we;
        logic [7:0]  data_be;
        logic [1:0]  data_size;
        logic [3:0]  data_id;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [3:0]  data_rid;
        logic [63:0] data_rdata;
        logic        data_ruser;
    } dcache_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LSU  = 2'd1,
        ARB_SHRU = 2'd2
    } arb_state_e;

    // Which requester drives the cache port in the current cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LSU  = 2'd1,
        SEL_SHRU = 2'd2
    } arb_sel_e;

endpackage

// File: rtl/shadow_dcache_arbiter.sv
// Shares one dcache request port between the LSU store path and the shadow register
// save controller; ShRU has priority, the LSU is guaranteed a win after MAX_STALL cycles.
module shadow_dcache_arbiter
    import shadow_dcache_arbiter_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg        = cva6_cfg_empty,
    parameter type         dcache_req_i_t = dcache_req_t,
    parameter type         dcache_req_o_t = dcache_rsp_t,
    parameter int unsigned MAX_STALL      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  dcache_req_i_t       shru_req_i,
    output dcache_req_o_t       shru_rsp_o,
    input  dcache_req_i_t       lsu_req_i,
    output dcache_req_o_t       lsu_rsp_o,
    output dcache_req_i_t       dcache_req_o,
    input  dcache_req_o_t       dcache_rsp_i,
    output logic [STALL_W-1:0]  lsu_stall_cnt_o,
    output logic                shru_owner_o
);

    localparam logic [STALL_W-1:0] MaxStall = STALL_W'(MAX_STALL);

    arb_state_e         state_q, state_d;
    arb_sel_e           sel;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               gnt_lsu, gnt_shru;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : select
        sel = SEL_NONE;
        case (state_q)
            ARB_IDLE: begin
                if (shru_req_i.data_req && lsu_req_i.data_req) begin
                    sel = (stall_cnt_q == MaxStall) ? SEL_LSU : SEL_SHRU;
                end else if (shru_req_i.data_req) begin
                    sel = SEL_SHRU;
                end else if (lsu_req_i.data_req) begin
                    sel = SEL_LSU;
                end
            end
            ARB_LSU:  sel = SEL_LSU;
            ARB_SHRU: sel = SEL_SHRU;
            default:  sel = SEL_NONE;
        endcase
        // Reset drops the lock at once, without waiting for a clock edge.
        if (rst_i) begin
            sel = SEL_NONE;
        end
    end

    always_comb begin : req_mux
        dcache_req_o = lsu_req_i;
        if (sel == SEL_SHRU) begin
            dcache_req_o = shru_req_i;
        end else if (sel == SEL_NONE) begin
            dcache_req_o.data_req = 1'b0;
        end
    end

    assign gnt_lsu  = dcache_rsp_i.data_gnt && (sel == SEL_LSU);
    assign gnt_shru = dcache_rsp_i.data_gnt && (sel == SEL_SHRU);

    // Read data always belongs to the LSU; saves are write-only.
    always_comb begin : rsp_route
        lsu_rsp_o           = dcache_rsp_i;
        lsu_rsp_o.data_gnt  = gnt_lsu;
        shru_rsp_o          = '0;
        shru_rsp_o.data_gnt = gnt_shru;
    end

    always_comb begin : next_state
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (!dcache_rsp_i.data_gnt) begin
                    if (sel == SEL_LSU) begin
                        state_d = ARB_LSU;
                    end else if (sel == SEL_SHRU) begin
                        state_d = ARB_SHRU;
                    end
                end
            end
            ARB_LSU: begin
                if (dcache_rsp_i.data_gnt || !lsu_req_i.data_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SHRU: begin
                if (dcache_rsp_i.data_gnt || !shru_req_i.data_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (gnt_lsu) begin
            stall_cnt_d = '0;
        end else if (lsu_req_i.data_req && (sel != SEL_LSU) && (stall_cnt_q < MaxStall)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign lsu_stall_cnt_o = stall_cnt_q;
    assign shru_owner_o    = (sel == SEL_SHRU);

`ifndef SYNTHESIS
    localparam bit CfgOk = (CVA6Cfg.XLEN == 0) || (CVA6Cfg.XLEN == 32) || (CVA6Cfg.XLEN == 64);

    a_params: assert property (@(posedge clk_i)
        CfgOk && (MAX_STALL >= 1) && (MAX_STALL <= 255))
        else $error("illegal configuration or MAX_STALL out of 1..255");

    a_lsu_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (lsu_req_i.data_req && !gnt_lsu) |=> (lsu_req_i.data_req && $stable(lsu_req_i)))
        else $error("LSU request changed before data_gnt");

    a_shru_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (shru_req_i.data_req && !gnt_shru) |=> (shru_req_i.data_req && $stable(shru_req_i)))
        else $error("ShRU request changed before data_gnt");

    a_owner_holds: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != ARB_IDLE) |-> ((state_q == ARB_LSU) ? lsu_req_i.data_req : shru_req_i.data_req))
        else $error("lock owner dropped data_req before data_gnt");

    a_one_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
        !(gnt_lsu && gnt_shru))
        else $error("data_gnt given to both requesters");

    a_stall_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        stall_cnt_q <= MaxStall)
        else $error("stall counter above MAX_STALL");
`endif

endmodule

// File: tb/tb_shadow_dcache_arbiter.sv
// Self-checking bench for shadow_dcache_arbiter: scenario tasks with inline checks plus
// a grant scoreboard filled at stimulus time and drained whenever a grant is seen.
module tb_shadow_dcache_arbiter;
    import shadow_dcache_arbiter_pkg::*;

    typedef struct packed {
        logic        shru;
        logic [11:0] idx;
    } exp_t;

    logic        clk_i;
    logic        rst_i;
    dcache_req_t shru_req, lsu_req, dreq;
    dcache_rsp_t shru_rsp, lsu_rsp, drsp;
    logic [7:0]  stall_cnt;
    logic        shru_owner;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    shadow_dcache_arbiter #(
        .CVA6Cfg        (cva6_cfg_empty),
        .dcache_req_i_t (dcache_req_t),
        .dcache_req_o_t (dcache_rsp_t),
        .MAX_STALL      (3)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .shru_req_i      (shru_req),
        .shru_rsp_o      (shru_rsp),
        .lsu_req_i       (lsu_req),
        .lsu_rsp_o       (lsu_rsp),
        .dcache_req_o    (dreq),
        .dcache_rsp_i    (drsp),
        .lsu_stall_cnt_o (stall_cnt),
        .shru_owner_o    (shru_owner)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic dcache_req_t mk_req(input logic [11:0] idx, input logic [63:0] wd, input logic we);
        dcache_req_t r;
        r               = '0;
        r.address_index = idx;
        r.address_tag   = {8'h5A, idx};
        r.data_wdata    = wd;
        r.data_req      = 1'b1;
        r.data_we       = we;
        r.data_be       = 8'hFF;
        r.data_size     = 2'd3;
        r.data_id       = idx[3:0];
        r.tag_valid     = 1'b1;
        return r;
    endfunction

    // Grant scoreboard: each grant must match the oldest expected requester/address.
    always @(negedge clk_i) begin
        if (!rst_i && (lsu_rsp.data_gnt || shru_rsp.data_gnt)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_grant: unexpected grant idx=%h shru=%0b", dreq.address_index, shru_rsp.data_gnt);
            end else begin
                mon_e = sb_q.pop_front();
                if (shru_rsp.data_gnt !== mon_e.shru || lsu_rsp.data_gnt !== !mon_e.shru ||
                    dreq.address_index !== mon_e.idx || dreq.data_req !== 1'b1) begin
                    bad++;
                    $display("FAIL sb_grant: got shru=%0b lsu=%0b idx=%h req=%0b exp shru=%0b idx=%h",
                             shru_rsp.data_gnt, lsu_rsp.data_gnt, dreq.address_index, dreq.data_req,
                             mon_e.shru, mon_e.idx);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        lsu_req  = mk_req(12'h111, 64'h1, 1'b1);
        shru_req = mk_req(12'h222, 64'h2, 1'b1);
        drsp = '0;
        drsp.data_gnt = 1'b1;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++; if (dreq.data_req !== 1'b0) begin bad++; $display("FAIL rst_data_req: got=%0b exp=0", dreq.data_req); end
        total++; if (lsu_rsp.data_gnt !== 1'b0 || shru_rsp.data_gnt !== 1'b0) begin
            bad++; $display("FAIL rst_gnt: got lsu=%0b shru=%0b exp 0 0", lsu_rsp.data_gnt, shru_rsp.data_gnt); end
        total++; if (shru_owner !== 1'b0) begin bad++; $display("FAIL rst_owner: got=%0b exp=0", shru_owner); end
        total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got=%0d exp=0", stall_cnt); end
        lsu_req = mk_req(12'h0EE, 64'h3, 1'b1);
        lsu_req.data_req = 1'b0;
        shru_req = '0;
        drsp = '0;
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (dreq.data_req !== 1'b0 || dreq.address_index !== 12'h0EE) begin
            bad++; $display("FAIL idle_payload: got req=%0b idx=%h exp req=0 idx=0ee", dreq.data_req, dreq.address_index); end
        next_cycle();
    endtask

    task automatic test_lsu_only();
        lsu_req = mk_req(12'h100, 64'hCAFE, 1'b1);
        sb_q.push_back({1'b0, 12'h100});
        for (int c = 0; c < 3; c++) begin
            drsp.data_gnt = (c == 2);
            @(negedge clk_i);
            total++; if (dreq !== lsu_req) begin bad++; $display("FAIL lsu_mirror c%0d: got idx=%h exp idx=%h", c, dreq.address_index, lsu_req.address_index); end
            total++; if (lsu_rsp.data_gnt !== (c == 2)) begin bad++; $display("FAIL lsu_gnt c%0d: got=%0b", c, lsu_rsp.data_gnt); end
            total++; if (shru_rsp.data_gnt !== 1'b0) begin bad++; $display("FAIL lsu_only_shru_gnt c%0d: got=%0b exp=0", c, shru_rsp.data_gnt); end
            next_cycle();
        end
        lsu_req.data_req = 1'b0;
        drsp = '0;
        next_cycle();
    endtask

    task automatic test_priority();
        bit exp_shru [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int exp_cnt  [5] = '{0, 1, 2, 3, 0};
        logic [11:0] s_idx = 12'h400;
        lsu_req = mk_req(12'h200, 64'h2222, 1'b1);
        drsp = '0;
        drsp.data_gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) lsu_req.data_req = 1'b0;
            shru_req = mk_req(s_idx, {52'h0, s_idx}, 1'b1);
            sb_q.push_back(exp_shru[c] ? {1'b1, s_idx} : {1'b0, 12'h200});
            @(negedge clk_i);
            total++; if (shru_owner !== exp_shru[c] || lsu_rsp.data_gnt !== !exp_shru[c]) begin
                bad++; $display("FAIL prio_order c%0d: got owner=%0b lsu_gnt=%0b exp owner=%0b", c, shru_owner, lsu_rsp.data_gnt, exp_shru[c]); end
            total++; if (stall_cnt !== 8'(exp_cnt[c])) begin
                bad++; $display("FAIL prio_cnt c%0d: got=%0d exp=%0d", c, stall_cnt, exp_cnt[c]); end
            if (exp_shru[c]) s_idx = s_idx + 12'd1;
            next_cycle();
        end
        shru_req.data_req = 1'b0;
        drsp = '0;
        next_cycle();
    endtask

    task automatic test_lock();
        int exp_cnt [8] = '{0, 0, 0, 1, 2, 3, 3, 0};
        shru_req = mk_req(12'h300, 64'hAAAA_0000_5555_FFFF, 1'b1);
        sb_q.push_back({1'b1, 12'h300});
        for (int c = 0; c < 8; c++) begin
            if (c == 2) lsu_req = mk_req(12'h140, 64'hBBBB_1234, 1'b1);
            if (c == 6) begin
                shru_req.data_req = 1'b0;
                sb_q.push_back({1'b0, 12'h140});
            end
            if (c == 7) lsu_req.data_req = 1'b0;
            drsp.data_gnt = (c == 5) || (c == 6);
            @(negedge clk_i);
            if (c <= 5) begin
                total++; if (dreq !== shru_req || shru_owner !== 1'b1 || lsu_rsp.data_gnt !== 1'b0) begin
                    bad++; $display("FAIL lock_payload c%0d: got idx=%h wd=%h owner=%0b lsu_gnt=%0b exp idx=300 owner=1",
                                    c, dreq.address_index, dreq.data_wdata, shru_owner, lsu_rsp.data_gnt); end
            end else if (c == 6) begin
                total++; if (dreq !== lsu_req || lsu_rsp.data_gnt !== 1'b1 || shru_owner !== 1'b0) begin
                    bad++; $display("FAIL lock_handover: got idx=%h lsu_gnt=%0b owner=%0b exp idx=140 gnt=1 owner=0",
                                    dreq.address_index, lsu_rsp.data_gnt, shru_owner); end
            end
            total++; if (stall_cnt !== 8'(exp_cnt[c])) begin
                bad++; $display("FAIL lock_cnt c%0d: got=%0d exp=%0d", c, stall_cnt, exp_cnt[c]); end
            next_cycle();
        end
        drsp = '0;
    endtask

    task automatic test_rvalid();
        shru_req = mk_req(12'h0A0, 64'h77, 1'b1);
        sb_q.push_back({1'b1, 12'h0A0});
        drsp = '0;
        @(negedge clk_i);
        total++; if (shru_owner !== 1'b1) begin bad++; $display("FAIL rv_owner: got=%0b exp=1", shru_owner); end
        next_cycle();
        drsp.data_rvalid = 1'b1;
        drsp.data_rdata  = 64'hDEAD;
        drsp.data_rid    = 4'd5;
        @(negedge clk_i);
        total++; if (lsu_rsp.data_rvalid !== 1'b1 || lsu_rsp.data_rdata !== 64'hDEAD || lsu_rsp.data_rid !== 4'd5) begin
            bad++; $display("FAIL rv_lsu: got v=%0b d=%h id=%0d exp v=1 d=dead id=5",
                            lsu_rsp.data_rvalid, lsu_rsp.data_rdata, lsu_rsp.data_rid); end
        total++; if (shru_rsp.data_rvalid !== 1'b0 || shru_rsp.data_gnt !== 1'b0) begin
            bad++; $display("FAIL rv_shru: got v=%0b gnt=%0b exp 0 0", shru_rsp.data_rvalid, shru_rsp.data_gnt); end
        next_cycle();
        drsp = '0;
        drsp.data_gnt = 1'b1;
        @(negedge clk_i);
        total++; if (shru_rsp.data_gnt !== 1'b1) begin bad++; $display("FAIL rv_shru_gnt: got=%0b exp=1", shru_rsp.data_gnt); end
        next_cycle();
        shru_req.data_req = 1'b0;
        drsp = '0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int exp_cnt [5] = '{0, 1, 2, 3, 3};
        shru_req = mk_req(12'h050, 64'h50, 1'b1);
        lsu_req  = mk_req(12'h060, 64'h60, 1'b1);
        sb_q.push_back({1'b1, 12'h050});
        drsp = '0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) shru_req.data_req = 1'b0;
            drsp.data_gnt = (c == 2);
            @(negedge clk_i);
            total++; if (stall_cnt !== 8'(exp_cnt[c])) begin
                bad++; $display("FAIL rm_cnt c%0d: got=%0d exp=%0d", c, stall_cnt, exp_cnt[c]); end
            if (c >= 3) begin
                total++; if (dreq !== lsu_req || shru_owner !== 1'b0) begin
                    bad++; $display("FAIL rm_lsu_lock c%0d: got idx=%h req=%0b owner=%0b exp idx=060 req=1", c, dreq.address_index, dreq.data_req, shru_owner); end
            end
            if (c < 4) next_cycle();
        end
        #2;
        rst_i = 1'b1;
        drsp.data_gnt = 1'b1;
        #1;
        total++; if (dreq.data_req !== 1'b0 || lsu_rsp.data_gnt !== 1'b0 || stall_cnt !== 8'd0) begin
            bad++; $display("FAIL rm_async: got req=%0b gnt=%0b cnt=%0d exp 0 0 0", dreq.data_req, lsu_rsp.data_gnt, stall_cnt); end
        lsu_req  = '0;
        shru_req = '0;
        next_cycle();
        rst_i = 1'b0;
        shru_req = mk_req(12'h070, 64'h70, 1'b1);
        sb_q.push_back({1'b1, 12'h070});
        @(negedge clk_i);
        total++; if (shru_rsp.data_gnt !== 1'b1 || shru_owner !== 1'b1 || stall_cnt !== 8'd0) begin
            bad++; $display("FAIL rm_after: got gnt=%0b owner=%0b cnt=%0d exp 1 1 0", shru_rsp.data_gnt, shru_owner, stall_cnt); end
        next_cycle();
        shru_req.data_req = 1'b0;
        drsp = '0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drsp = '0;
        lsu_req = mk_req(12'h010, 64'h10, 1'b1);
        drsp.data_gnt = 1'b1;
        sb_q.push_back({1'b0, 12'h010});
        @(negedge clk_i);
        total++; if (lsu_rsp.data_gnt !== 1'b1) begin bad++; $display("FAIL b2b_c0: got=%0b exp=1", lsu_rsp.data_gnt); end
        next_cycle();
        lsu_req.data_req = 1'b0;
        shru_req = mk_req(12'h020, 64'h20, 1'b1);
        sb_q.push_back({1'b1, 12'h020});
        @(negedge clk_i);
        total++; if (shru_rsp.data_gnt !== 1'b1) begin bad++; $display("FAIL b2b_c1: got=%0b exp=1", shru_rsp.data_gnt); end
        next_cycle();
        shru_req.data_req = 1'b0;
        lsu_req = mk_req(12'h030, 64'h30, 1'b1);
        drsp.data_gnt = 1'b0;
        sb_q.push_back({1'b0, 12'h030});
        @(negedge clk_i);
        total++; if (lsu_rsp.data_gnt !== 1'b0 || dreq.address_index !== 12'h030) begin
            bad++; $display("FAIL b2b_c2: got gnt=%0b idx=%h exp 0 030", lsu_rsp.data_gnt, dreq.address_index); end
        next_cycle();
        shru_req = mk_req(12'h040, 64'h40, 1'b1);
        drsp.data_gnt = 1'b1;
        sb_q.push_back({1'b1, 12'h040});
        @(negedge clk_i);
        total++; if (lsu_rsp.data_gnt !== 1'b1 || shru_rsp.data_gnt !== 1'b0 || dreq !== lsu_req) begin
            bad++; $display("FAIL b2b_c3: got lsu=%0b shru=%0b idx=%h exp 1 0 030", lsu_rsp.data_gnt, shru_rsp.data_gnt, dreq.address_index); end
        next_cycle();
        lsu_req.data_req = 1'b0;
        @(negedge clk_i);
        total++; if (shru_rsp.data_gnt !== 1'b1 || dreq !== shru_req) begin
            bad++; $display("FAIL b2b_c4: got gnt=%0b idx=%h exp 1 040", shru_rsp.data_gnt, dreq.address_index); end
        next_cycle();
        shru_req.data_req = 1'b0;
        drsp = '0;
        next_cycle();
    endtask

    initial begin
        rst_i    = 1'b1;
        lsu_req  = '0;
        shru_req = '0;
        drsp     = '0;
        test_reset();
        test_lsu_only();
        test_priority();
        test_lock();
        test_rvalid();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding grants exp 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
